joy_shift_reader: RTL and testbench

Serial front end for the two-pad joystick port. On every horizontal sync it loads the external parallel-in/serial-out shift-register chain and clocks out 24 bits. It then presents them as two 12-bit negative-logic pad words, MXYZ SACB RLDU (bit 11 = M … bit 0 = U). Downstream, the joystick mapper consumes `joy1_o`/`joy2_o` and builds the 8-bit active-high port value.

---
 rtl/joy_pkg.sv | 31 +++
 rtl/sync_fall.sv | 27 ++
 rtl/joy_shift_reader.sv | 104 ++++++++++
 tb/tb_joy_shift_reader.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
// Shared definitions for the joystick shift-register front end and the downstream mapper.
package joy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CKLO,
    ST_CKHI,
    ST_DONE
  } joy_state_t;

  localparam int unsigned JOY_BITS  = 12;
  localparam int unsigned JOY_CHAIN = 24;

  localparam logic [JOY_BITS-1:0] JOY_IDLE = 12'hFFF;

  // Pad word layout MXYZ SACB RLDU, negative logic
  localparam int unsigned JOY_M = 11;
  localparam int unsigned JOY_X = 10;
  localparam int unsigned JOY_Y = 9;
  localparam int unsigned JOY_Z = 8;
  localparam int unsigned JOY_S = 7;
  localparam int unsigned JOY_A = 6;
  localparam int unsigned JOY_C = 5;
  localparam int unsigned JOY_B = 4;
  localparam int unsigned JOY_R = 3;
  localparam int unsigned JOY_L = 2;
  localparam int unsigned JOY_D = 1;
  localparam int unsigned JOY_U = 0;

endpackage

// File: rtl/sync_fall.sv
// Two-flop synchronizer plus falling-edge detector; emits a one-cycle pulse.
module sync_fall #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic pulse_c
);

  logic s1, s2, s3;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse_c = s3 & ~s2;

endmodule

// File: rtl/joy_shift_reader.sv
// Loads and shifts the external 24-bit PISO chain on each hsync fall and
// publishes two 12-bit negative-logic pad words.
module joy_shift_reader
  import joy_pkg::*;
#(
  parameter int unsigned DIV   = 4,
  parameter int unsigned NBITS = JOY_BITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hsync,
  input  logic             joyD,
  output logic             joyCk,
  output logic             joyLd,
  output logic [NBITS-1:0] joy1_o,
  output logic [NBITS-1:0] joy2_o,
  output logic             valid
);

  localparam int unsigned DW = $clog2(2 * DIV);
  localparam int unsigned CW = 2 * NBITS;

  joy_state_t    state;
  logic [DW-1:0] div;
  logic [4:0]    idx;
  logic [CW-1:0] sreg;
  logic          start_c;
  logic          ld_end_c;
  logic          ck_end_c;

  sync_fall #(.RST_VAL(1'b1)) u_sync (
    .clock   (clock),
    .reset   (reset),
    .async_in(hsync),
    .pulse_c (start_c)
  );

  assign ld_end_c = (div == DW'(2 * DIV - 1));
  assign ck_end_c = (div == DW'(DIV - 1));

  // Scan sequencer; outputs are published on entry to DONE so valid and data coincide
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      div    <= '0;
      idx    <= '0;
      sreg   <= '1;
      joyCk  <= 1'b0;
      joyLd  <= 1'b1;
      joy1_o <= NBITS'(JOY_IDLE);
      joy2_o <= NBITS'(JOY_IDLE);
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      div   <= div + DW'(1);
      case (state)
        ST_IDLE: begin
          div <= '0;
          if (start_c) begin
            state <= ST_LOAD;
            joyLd <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (ld_end_c) begin
            state <= ST_CKLO;
            joyLd <= 1'b1;
            div   <= '0;
            idx   <= '0;
          end
        end
        ST_CKLO: begin
          if (ck_end_c) begin
            sreg  <= {sreg[CW-2:0], joyD};
            joyCk <= 1'b1;
            state <= ST_CKHI;
            div   <= '0;
          end
        end
        ST_CKHI: begin
          if (ck_end_c) begin
            joyCk <= 1'b0;
            div   <= '0;
            if (idx == 5'(JOY_CHAIN - 1)) begin
              state  <= ST_DONE;
              joy1_o <= sreg[CW-1:NBITS];
              joy2_o <= sreg[NBITS-1:0];
              valid  <= 1'b1;
            end else begin
              idx   <= idx + 5'd1;
              state <= ST_CKLO;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          div   <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_joy_shift_reader.sv
// Scoreboard bench for joy_shift_reader with a behavioural PISO chain model.
module tb_joy_shift_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        hsync;
  logic        joyD;
  logic        joyCk;
  logic        joyLd;
  logic [11:0] joy1_o;
  logic [11:0] joy2_o;
  logic        valid;

  joy_shift_reader #(.DIV(4), .NBITS(12)) dut (
    .clock (clock),
    .reset (reset),
    .hsync (hsync),
    .joyD  (joyD),
    .joyCk (joyCk),
    .joyLd (joyLd),
    .joy1_o(joy1_o),
    .joy2_o(joy2_o),
    .valid (valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] j1;
    logic [11:0] j2;
    int          t;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ck_count = 0;
  int valid_count = 0;
  int stab_bad = 0;
  int ld_fall_cyc = 0;
  int t0 = 0;
  logic ld_prev = 1'b1;
  logic [11:0] l1 = 12'hFFF;
  logic [11:0] l2 = 12'hFFF;

  // Chain model: parallel load while joyLd low, shift on joyCk rise
  logic [23:0] chain_data = '1;
  logic [23:0] chain_sh = '1;
  always @(negedge joyLd or posedge joyCk) begin
    if (!joyLd) chain_sh <= chain_data;
    else        chain_sh <= {chain_sh[22:0], 1'b1};
  end
  assign joyD = chain_sh[23];

  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge joyCk) ck_count <= ck_count + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops scoreboard on valid, tracks output stability and load timing
  always @(negedge clock) begin
    ld_prev <= joyLd;
    if (ld_prev && !joyLd) ld_fall_cyc <= cyc;
    if (valid === 1'b1) begin
      valid_count <= valid_count + 1;
      l1 <= joy1_o;
      l2 <= joy2_o;
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got joy1=%h joy2=%h with no scan pending", joy1_o, joy2_o);
      end else begin
        e = q.pop_front();
        check("joy1", 32'(joy1_o), 32'(e.j1));
        check("joy2", 32'(joy2_o), 32'(e.j2));
        check("valid_latency", 32'(cyc), 32'(e.t));
      end
    end else if (reset === 1'b1) begin
      l1 <= 12'hFFF;
      l2 <= 12'hFFF;
    end else if (joy1_o !== l1 || joy2_o !== l2) begin
      stab_bad <= stab_bad + 1;
    end
  end

  task automatic scan(input logic [23:0] data, input bit push, output int ck_base);
    @(posedge clock);
    #1;
    chain_data = data;
    hsync = 1'b0;
    t0 = cyc;
    ck_base = ck_count;
    if (push) q.push_back('{j1: data[23:12], j2: data[11:0], t: t0 + 203});
    repeat (8) @(posedge clock);
    #1 hsync = 1'b1;
  endtask

  initial begin
    int ckb;
    int vb;
    int bad;
    logic [23:0] b2b [4];
    b2b[0] = 24'hFFF000;
    b2b[1] = 24'h0F0F0F;
    b2b[2] = 24'hEDCBA9;
    b2b[3] = 24'h000FFF;

    reset = 1'b1;
    hsync = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_joy1", 32'(joy1_o), 32'hFFF);
    check("rst_joy2", 32'(joy2_o), 32'hFFF);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_joyLd", 32'(joyLd), 32'h1);
    check("rst_joyCk", 32'(joyCk), 32'h0);
    reset = 1'b0;

    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (joy1_o !== 12'hFFF || joy2_o !== 12'hFFF || valid !== 1'b0 || joyLd !== 1'b1 || joyCk !== 1'b0)
        bad++;
    end
    check("idle_hold", 32'(bad), 32'h0);

    // Single scan
    vb = valid_count;
    scan(24'hFFE7FF, 1'b1, ckb);
    repeat (250) @(posedge clock);
    check("ld_latency", 32'(ld_fall_cyc - t0), 32'd3);
    check("ck_edges_1", 32'(ck_count - ckb), 32'd24);
    check("valid_once_1", 32'(valid_count - vb), 32'd1);

    // Bit order
    scan(24'h800001, 1'b1, ckb);
    repeat (250) @(posedge clock);
    check("ck_edges_2", 32'(ck_count - ckb), 32'd24);

    // Second hsync fall 50 cycles into the scan is ignored
    vb = valid_count;
    scan(24'h5A3C96, 1'b1, ckb);
    repeat (45) @(posedge clock);
    #1 hsync = 1'b0;
    repeat (8) @(posedge clock);
    #1 hsync = 1'b1;
    repeat (250) @(posedge clock);
    check("valid_once_mid", 32'(valid_count - vb), 32'd1);
    check("ck_edges_mid", 32'(ck_count - ckb), 32'd24);

    // Reset during CKHI of bit 10
    vb = valid_count;
    scan(24'h123456, 1'b0, ckb);
    repeat (89) @(posedge clock);
    #1;
    check("pre_rst_ckhi", 32'(joyCk), 32'h1);
    check("pre_rst_edges", 32'(ck_count - ckb), 32'd11);
    reset = 1'b1;
    #1;
    check("mid_rst_joyCk", 32'(joyCk), 32'h0);
    check("mid_rst_joyLd", 32'(joyLd), 32'h1);
    check("mid_rst_joy1", 32'(joy1_o), 32'hFFF);
    check("mid_rst_joy2", 32'(joy2_o), 32'hFFF);
    check("mid_rst_valid", 32'(valid), 32'h0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (300) @(posedge clock);
    check("no_valid_after_rst", 32'(valid_count - vb), 32'd0);
    scan(24'h123456, 1'b1, ckb);
    repeat (250) @(posedge clock);
    check("ck_edges_post_rst", 32'(ck_count - ckb), 32'd24);

    // Back-to-back lines every 256 cycles
    vb = valid_count;
    for (int i = 0; i < 4; i++) begin
      scan(b2b[i], 1'b1, ckb);
      repeat (247) @(posedge clock);
    end
    check("b2b_valid_count", 32'(valid_count - vb), 32'd4);

    for (int i = 0; i < 500 && q.size() != 0; i++) @(posedge clock);
    check("scoreboard_drain", 32'(q.size()), 32'd0);
    @(negedge clock);
    check("output_stability", 32'(stab_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
